// File: rtl/iccm_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : iccm_arb_pkg                                           |
// | Description : Shared types and constants for the ICCM arbiter.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package iccm_arb_pkg;

  // Arbiter session state: core running, image being programmed, settle window
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PROG = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Width of the programmed-word counter
  localparam int ProgCntW = 16;

endpackage
`default_nettype wire

// File: rtl/iccm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : iccm_arbiter                                           |
// | Description : Shares the single-port ICCM between the UART boot      |
// |               programmer and the core's TL-UL SRAM adapter. The      |
// |               programmer always wins; a session holds the core in    |
// |               reset until the image is loaded and a settle window    |
// |               has elapsed. Stalled sessions raise a sticky timeout.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module iccm_arbiter
  import iccm_arb_pkg::*;
#(
  parameter int AW          = 12,
  parameter int DW          = 32,
  parameter int HoldCycles  = 16,
  parameter int ProgTimeout = 2**20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // programmer side
  input  logic                prog_we_i,
  input  logic [AW-1:0]       prog_addr_i,
  input  logic [DW-1:0]       prog_wdata_i,
  input  logic                prog_done_i,
  // adapter side
  input  logic                bus_req_i,
  input  logic                bus_we_i,
  input  logic [AW-1:0]       bus_addr_i,
  input  logic [DW-1:0]       bus_wdata_i,
  input  logic [DW-1:0]       bus_wmask_i,
  output logic                bus_gnt_o,
  output logic [DW-1:0]       bus_rdata_o,
  output logic                bus_rvalid_o,
  // memory side
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [AW-1:0]       mem_addr_o,
  output logic [DW-1:0]       mem_wdata_o,
  output logic [DW-1:0]       mem_wmask_o,
  input  logic [DW-1:0]       mem_rdata_i,
  input  logic                mem_rvalid_i,
  // status
  output logic                core_hold_o,
  output logic                prog_active_o,
  output logic [ProgCntW-1:0] prog_count_o,
  output logic                timeout_o
);

  localparam int IdleW = 32;
  localparam int HoldW = 16;

  // Last idle-counter value before a timeout fires; unused when ProgTimeout is 0
  localparam logic [IdleW-1:0] IdleLimit = IdleW'(ProgTimeout - 1);
  localparam logic [HoldW-1:0] HoldLoad  = HoldW'(HoldCycles - 1);

  state_e                r_state,   w_state_nxt;
  logic [IdleW-1:0]      r_idle,    w_idle_nxt;
  logic [HoldW-1:0]      r_hold,    w_hold_nxt;
  logic [ProgCntW-1:0]   r_count,   w_count_nxt;
  logic                  r_timeout, w_timeout_nxt;
  logic                  r_core_hold;
  logic [ProgCntW-1:0]   w_count_sat;
  logic                  w_idle_expired;

  // Saturating increment of the word counter
  assign w_count_sat    = (&r_count) ? r_count : r_count + ProgCntW'(1);
  assign w_idle_expired = (ProgTimeout != 0) && (r_idle == IdleLimit);

  // State register and counters; async reset drops the core hold immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= RUN;
      r_idle      <= '0;
      r_hold      <= '0;
      r_count     <= '0;
      r_timeout   <= 1'b0;
      r_core_hold <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idle      <= w_idle_nxt;
      r_hold      <= w_hold_nxt;
      r_count     <= w_count_nxt;
      r_timeout   <= w_timeout_nxt;
      r_core_hold <= (w_state_nxt != RUN);
    end
  end

  // Next-state and counter update; a write always counts, even alongside done
  always_comb begin
    w_state_nxt   = r_state;
    w_idle_nxt    = r_idle;
    w_hold_nxt    = r_hold;
    w_count_nxt   = r_count;
    w_timeout_nxt = r_timeout;
    case (r_state)
      RUN: begin
        if (prog_we_i) begin
          w_state_nxt = PROG;
          w_count_nxt = ProgCntW'(1);
          w_idle_nxt  = '0;
        end
      end
      PROG: begin
        if (prog_we_i) begin
          w_count_nxt = w_count_sat;
          w_idle_nxt  = '0;
        end
        if (prog_done_i) begin
          w_state_nxt = HOLD;
          w_hold_nxt  = HoldLoad;
        end else if (!prog_we_i) begin
          if (w_idle_expired) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = HOLD;
            w_hold_nxt    = HoldLoad;
          end else begin
            w_idle_nxt = r_idle + IdleW'(1);
          end
        end
      end
      HOLD: begin
        if (prog_we_i) begin
          // Resume the session without clearing the word count
          w_state_nxt = PROG;
          w_count_nxt = w_count_sat;
          w_idle_nxt  = '0;
        end else if (r_hold == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_hold_nxt = r_hold - HoldW'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  assign bus_gnt_o = (r_state == RUN) && !prog_we_i;

  // Memory port mux: programmer write has absolute priority, adapter only when granted
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (prog_we_i) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = prog_addr_i;
      mem_wdata_o = prog_wdata_i;
      mem_wmask_o = '1;
    end else if (bus_gnt_o) begin
      mem_req_o   = bus_req_i;
      mem_we_o    = bus_req_i & bus_we_i;
      mem_addr_o  = bus_addr_i;
      mem_wdata_o = bus_wdata_i;
      mem_wmask_o = bus_wmask_i;
    end
  end

  // Read return is a straight pass-through so in-flight reads always complete
  assign bus_rdata_o   = mem_rdata_i;
  assign bus_rvalid_o  = mem_rvalid_i;

  assign core_hold_o   = r_core_hold;
  assign prog_active_o = (r_state == PROG);
  assign prog_count_o  = r_count;
  assign timeout_o     = r_timeout;

endmodule
`default_nettype wire

// File: doc/iccm_arbiter.md
# iccm_arbiter

Shares the single-port instruction memory (ICCM) between the UART boot programmer (`iccm_controller`) and the core's TL-UL SRAM adapter. The programmer always wins, and a programming session holds the core in reset until the image is loaded and a settle window has elapsed. A timeout flags sessions that stall. The block sits between `iccm_controller`/`tlul_sram_adapter` and `instr_mem_top`; `core_hold_o` feeds the reset manager.

## Interface
- `AW`, default 12: word address width.
- `DW`, default 32: data width.
- `HoldCycles`, default 16: core-hold cycles after `prog_done_i`; legal range 1..65535.
- `ProgTimeout`, default 2^20: idle cycles in PROG before timeout; 0 disables the timeout.

Ports:
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `prog_we_i`  in  1  programmer write strobe, one cycle per word; never stalled.
- `prog_addr_i`  in  AW  programmer word address.
- `prog_wdata_i`  in  DW  programmer write data.
- `prog_done_i`  in  1  one-cycle pulse: image complete.
- `bus_req_i`  in  1  adapter request.
- `bus_we_i`  in  1  adapter write.
- `bus_addr_i`  in  AW  adapter address.
- `bus_wdata_i`  in  DW  adapter write data.
- `bus_wmask_i`  in  DW  adapter bit mask.
- `bus_gnt_o`  out  1  grant to adapter.
- `bus_rdata_o`  out  DW  read data.
- `bus_rvalid_o`  out  1  read valid.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  memory write.
- `mem_addr_o`  out  AW  memory address.
- `mem_wdata_o`  out  DW  memory write data.
- `mem_wmask_o`  out  DW  memory bit mask.
- `mem_rdata_i`  in  DW  memory read data, 1-cycle latency.
- `mem_rvalid_i`  in  1  memory read valid.
- `core_hold_o`  out  1  hold core in reset.
- `prog_active_o`  out  1  state is PROG.
- `prog_count_o`  out  16  words written in the current or last session; saturates at 0xFFFF.
- `timeout_o`  out  1  sticky; set on session timeout.

## Operation
- The FSM has three states: RUN, PROG, HOLD. Reset state is RUN.
- Memory mux (combinational):
  - When `prog_we_i`=1 in any state, the memory port carries the programmer write: req=1, we=1, wmask all-ones, prog address and data.
  - Otherwise, in RUN, the memory port carries the adapter signals, gated by `bus_gnt_o`.
- `bus_gnt_o` = (state==RUN) && !`prog_we_i`.
- Reads and writes are only granted in RUN.
- `bus_rdata_o` and `bus_rvalid_o` pass `mem_rdata_i` and `mem_rvalid_i` straight through. A read granted in cycle N returns in cycle N+1, even if the FSM has moved to PROG in N+1.
- RUN -> PROG on `prog_we_i`=1. In that same cycle `prog_count_o` is cleared to 0, then incremented for this write (value becomes 1).
- PROG:
  - Each `prog_we_i` increments `prog_count_o` and reloads the idle counter.
  - `prog_done_i` -> HOLD, with the hold counter loaded to `HoldCycles`-1.
  - If the idle counter reaches `ProgTimeout`, set `timeout_o` and go to HOLD.
- HOLD:
  - The hold counter decrements each cycle; at 0 -> RUN.
  - `prog_we_i` in HOLD -> PROG. The count continues (not cleared), and the write is performed and counted.
- `prog_done_i` outside PROG is ignored.
- If `prog_we_i` and `prog_done_i` arrive in the same cycle in PROG: the write is performed and counted, then -> HOLD.
- `core_hold_o` is registered and equals (next_state != RUN). It rises the cycle after the first programmer write and falls on the cycle the FSM enters RUN.
- `timeout_o` clears only on reset.

## Timing
- Reset values: `core_hold_o`=0, `prog_active_o`=0, `prog_count_o`=0, `timeout_o`=0, state RUN, all counters 0.
- Combinational outputs follow their inputs with no reset dependency.
- Memory path has zero added latency: a programmer write reaches the memory in the same cycle as `prog_we_i`.
- HOLD lasts exactly `HoldCycles` cycles.
- Asynchronous reset mid-session returns the block to RUN immediately with the hold released. An in-flight `mem_rvalid_i` is still passed through.

## Structure
- A shared package `iccm_arb_pkg` holds the `state_e` enum (RUN/PROG/HOLD) and the `ProgCntW`=16 localparam.
- No sub-modules: one FSM plus three counters (idle, hold, word count).

## Test plan
- Adapter read of 0x010 in RUN: expect `bus_gnt_o`=1 and `mem_addr_o`=0x010; next cycle `bus_rvalid_o`=1 with the memory data.
- Programmer write to 0x000 colliding with an adapter request: expect `bus_gnt_o`=0, `mem_wdata_o`=prog data, and `core_hold_o`=1 from the next cycle.
- 256 programmer writes followed by `prog_done_i`: expect `prog_count_o`=256, `core_hold_o` high for exactly 16 more cycles, then `bus_gnt_o`=1.
- `prog_we_i` on HOLD cycle 5: expect return to PROG and `prog_count_o` incremented, followed by a full 16-cycle HOLD after the next `prog_done_i`.
- With `ProgTimeout`=8, stall writes in PROG: after 8 idle cycles `timeout_o`=1, the FSM enters HOLD, then RUN.
- Assert `rst_ni`=0 in PROG: expect `core_hold_o`=0, `prog_count_o`=0, and `timeout_o`=0 asynchronously.
